// File: rtl/key_debounce_ctrl.sv
// key_debounce_ctrl: synchronises and debounces raw active-low push buttons.
// Each key gets its own 2-FF synchroniser, debounce FSM and counter. The block produces a clean
// level and one-cycle press/release pulses for each key.
// Optional long-press pulse: define KEY_LONG_PRESS_EN to build the per-key long counters.
// When the macro is not defined, key_long is tied to 0.
module key_debounce_ctrl #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int unsigned MaxCycles = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES
                                                                       : LONG_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_LONG_PRESS_EN
  localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
`endif

  typedef enum logic [1:0] {StIdle, StWaitDown, StDown, StWaitUp} state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] key_down;

  state_e [NUM_KEYS-1:0]          state_q, state_d;
  logic   [NUM_KEYS-1:0][CntW-1:0] cnt_q, cnt_d;
  logic   [NUM_KEYS-1:0]          level_q, level_d;
  logic   [NUM_KEYS-1:0]          press_q, press_d;
  logic   [NUM_KEYS-1:0]          release_q, release_d;
`ifdef KEY_LONG_PRESS_EN
  logic   [NUM_KEYS-1:0][CntW-1:0] long_cnt_q, long_cnt_d;
  logic   [NUM_KEYS-1:0]          long_q, long_d;
`endif

  // Raw pins are active-low, so an inverted synchroniser output reads as "down"
  assign key_down = ~sync2_q;

  // Next-state logic for each key's debounce FSM, counters and registered pulses
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      level_d[i]   = level_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
`ifdef KEY_LONG_PRESS_EN
      long_cnt_d[i] = long_cnt_q[i];
      long_d[i]     = 1'b0;
`endif
      unique case (state_q[i])
        StIdle: begin
          level_d[i] = 1'b0;
          if (key_down[i]) begin
            state_d[i] = StWaitDown;
            cnt_d[i]   = '0;
          end
        end
        StWaitDown: begin
          if (!key_down[i]) begin
            state_d[i] = StIdle;
          end else if (cnt_q[i] == DebLast) begin
            state_d[i] = StDown;
            press_d[i] = 1'b1;
            level_d[i] = 1'b1;
            cnt_d[i]   = '0;
`ifdef KEY_LONG_PRESS_EN
            long_cnt_d[i] = '0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        StDown: begin
          level_d[i] = 1'b1;
          if (!key_down[i]) begin
            state_d[i] = StWaitUp;
            cnt_d[i]   = '0;
          end
`ifdef KEY_LONG_PRESS_EN
          // Saturation at LongLast doubles as the fire-once flag
          else if (long_cnt_q[i] != LongLast) begin
            long_cnt_d[i] = long_cnt_q[i] + 1'b1;
            long_d[i]     = (long_cnt_d[i] == LongLast);
          end
`endif
        end
        StWaitUp: begin
          level_d[i] = 1'b1;
          if (key_down[i]) begin
            // Release bounce: resume DOWN with long-press status retained
            state_d[i] = StDown;
          end else if (cnt_q[i] == DebLast) begin
            state_d[i]   = StIdle;
            release_d[i] = 1'b1;
            level_d[i]   = 1'b0;
            cnt_d[i]     = '0;
`ifdef KEY_LONG_PRESS_EN
            long_cnt_d[i] = '0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // Synchroniser, FSM state, counters and output registers; async clear to released/idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= StIdle;
      end
`ifdef KEY_LONG_PRESS_EN
      long_cnt_q <= '0;
      long_q     <= '0;
`endif
    end else begin
      sync1_q   <= key_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_LONG_PRESS_EN
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
`endif
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
`ifdef KEY_LONG_PRESS_EN
  assign key_long    = long_q;
`else
  assign key_long    = '0;
`endif

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Testbench for key_debounce_ctrl with a small parameter set.
// It keeps a queue of expected pulse events, each stamped with the clock edge count at which it
// should appear. Every output pulse is popped and checked against the head of the queue.
module tb_key_debounce_ctrl;

  localparam int unsigned Nk  = 4;
  localparam int unsigned Deb = 8;
  localparam int unsigned Lng = 32;
  // Edge N captures the pin; the pulse is visible once N+Deb+2 edges have elapsed
  localparam int unsigned PulseDly = 1 + Deb + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [Nk-1:0] key_in = '1;
  logic [Nk-1:0] key_level, key_press, key_release, key_long;

  typedef struct {
    int unsigned   cyc;
    logic [Nk-1:0] press;
    logic [Nk-1:0] rel;
    logic [Nk-1:0] lng;
    logic [Nk-1:0] level;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned edge_cnt = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  key_debounce_ctrl #(
    .NUM_KEYS       (Nk),
    .DEBOUNCE_CYCLES(Deb),
    .LONG_CYCLES    (Lng)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input int unsigned dly, input logic [Nk-1:0] p, input logic [Nk-1:0] r,
                           input logic [Nk-1:0] l, input logic [Nk-1:0] lv);
    exp_q.push_back('{edge_cnt + dly, p, r, l, lv});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [Nk-1:0] v);
    @(negedge clk);
    key_in = v;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, exp_q.size(), 0);
    step(2);
  endtask

  // Monitor: sample away from the active edge and match pulses against the scoreboard
  always @(negedge clk) begin
    ev_t ev;
    if (rst_n) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < edge_cnt) begin
        check_eq("missed_event_cycle", edge_cnt, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if ((key_press | key_release | key_long) != '0) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_pulse", {20'd0, key_press, key_release, key_long}, 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check_eq("ev_cycle", edge_cnt, ev.cyc);
          check_eq("ev_press", key_press, ev.press);
          check_eq("ev_release", key_release, ev.rel);
          check_eq("ev_long", key_long, ev.lng);
          check_eq("ev_level", key_level, ev.level);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset with all keys held, then fresh qualification after deassert
    key_in = 4'h0;
    rst_n  = 1'b0;
    step(3);
    check_eq("rst_level", key_level, 4'h0);
    check_eq("rst_press", key_press, 4'h0);
    check_eq("rst_release", key_release, 4'h0);
    check_eq("rst_long", key_long, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_ev(PulseDly, 4'hF, 4'h0, 4'h0, 4'hF);
    drain("t1_press_drain");
    check_eq("t1_level_held", key_level, 4'hF);
    drive(4'hF);
    expect_ev(PulseDly, 4'h0, 4'hF, 4'h0, 4'h0);
    drain("t1_release_drain");

    // 2: short glitch rejected, then a real press and release
    drive(4'hE);
    step(4);
    drive(4'hF);
    step(15);
    check_eq("t2_glitch_level", key_level, 4'h0);
    drive(4'hE);
    expect_ev(PulseDly, 4'h1, 4'h0, 4'h0, 4'h1);
    step(20);
    drive(4'hF);
    expect_ev(PulseDly, 4'h0, 4'h1, 4'h0, 4'h0);
    drain("t2_drain");

    // 3: release of bit 2 with 3-cycle bounces gives a single release
    drive(4'hB);
    expect_ev(PulseDly, 4'h4, 4'h0, 4'h0, 4'h4);
    step(12);
    drive(4'hF);
    step(2);
    drive(4'hB);
    step(2);
    drive(4'hF);
    step(2);
    drive(4'hB);
    step(2);
    check_eq("t3_level_bounce", key_level, 4'h4);
    drive(4'hF);
    expect_ev(PulseDly, 4'h0, 4'h4, 4'h0, 4'h0);
    drain("t3_drain");

    // 4: simultaneous press on bits 1 and 3, independent releases
    drive(4'h5);
    expect_ev(PulseDly, 4'hA, 4'h0, 4'h0, 4'hA);
    step(12);
    drive(4'h7);
    expect_ev(PulseDly, 4'h0, 4'h2, 4'h0, 4'h8);
    step(12);
    check_eq("t4_level_partial", key_level, 4'h8);
    drive(4'hF);
    expect_ev(PulseDly, 4'h0, 4'h8, 4'h0, 4'h0);
    drain("t4_drain");

    // 5: long hold on bit 0; long pulse once when the feature is built
    drive(4'hE);
    expect_ev(PulseDly, 4'h1, 4'h0, 4'h0, 4'h1);
`ifdef KEY_LONG_PRESS_EN
    expect_ev(PulseDly + Lng - 1, 4'h0, 4'h0, 4'h1, 4'h1);
`endif
    step(100);
    check_eq("t5_long_idle", key_long, 4'h0);
    drive(4'hF);
    expect_ev(PulseDly, 4'h0, 4'h1, 4'h0, 4'h0);
    drain("t5_drain");

    // 6: asynchronous reset with bit 0 down and bit 2 mid-qualification (cnt=5)
    drive(4'hE);
    expect_ev(PulseDly, 4'h1, 4'h0, 4'h0, 4'h1);
    step(12);
    check_eq("t6_level_before", key_level, 4'h1);
    drive(4'hA);
    step(8);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_level", key_level, 4'h0);
    check_eq("t6_async_press", key_press, 4'h0);
    check_eq("t6_async_release", key_release, 4'h0);
    key_in = 4'hF;
    step(3);
    rst_n = 1'b1;
    step(25);
    check_eq("t6_level_after", key_level, 4'h0);
    drain("t6_drain");

    check_eq("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
